// File: rtl/decomp_stream_sequencer_pkg.sv
// decomp_pkg: shared FSM state encoding and header field constants for decomp_stream_sequencer.
package decomp_pkg;
   typedef enum logic [2:0] {IDLE, LOAD1, LOAD2, ISSUE, WAIT, DRAIN, DONE} seqState_t;
   localparam logic [2:0] BIT_IDX_FRESH = 3'd7;
   localparam int RUN_LEN_MSB = 6;
   localparam int RUN_VAL_BIT = 7;
endpackage

// File: rtl/decomp_stream_sequencer_if.sv
// decomp_stream_sequencer_if: compressed byte stream plus the decompress_handler pair bus.
interface decomp_stream_sequencer_if #(parameter int IDX_W = 32);
   logic s_valid;
   logic [7:0] s_data;
   logic s_ready;
   logic [7:0] in1_o;
   logic [7:0] in2_o;
   logic [IDX_W-1:0] byte_idx_o;
   logic [2:0] bit_idx_o;
   logic work_o;
   logic done_i;
   logic [IDX_W-1:0] new_byte_i;
   logic [2:0] new_bit_i;
   modport master (
      input  s_valid, s_data, done_i, new_byte_i, new_bit_i,
      output s_ready, in1_o, in2_o, byte_idx_o, bit_idx_o, work_o
   );
   modport slave (
      output s_valid, s_data, done_i, new_byte_i, new_bit_i,
      input  s_ready, in1_o, in2_o, byte_idx_o, bit_idx_o, work_o
   );
endinterface

// File: rtl/decomp_stream_sequencer_byte_fifo.sv
// byte_fifo: small power-of-two byte FIFO with flush; read data is the combinational head entry.
module byte_fifo #(
   parameter int DEPTH = 4
) (
   input  logic clk,
   input  logic RST,
   input  logic flush,
   input  logic push,
   input  logic pop,
   input  logic [7:0] din,
   output logic [7:0] dout,
   output logic full,
   output logic empty
);
   localparam int AW = $clog2(DEPTH);
   logic [7:0] mem [DEPTH];
   logic [AW-1:0] wrPtr, rdPtr;
   logic [AW:0] count;
   logic doPush, doPop;
   assign full = count[AW];
   assign empty = count == '0;
   // a pop frees the slot being written, so push-while-full is legal when popping too
   assign doPush = push & (~full | pop);
   assign doPop = pop & ~empty;
   assign dout = mem[rdPtr];
   always_ff @(posedge clk) begin
      if (doPush) mem[wrPtr] <= din;
   end
   always_ff @(posedge clk) begin
      if (RST | flush) begin
         wrPtr <= '0;
         rdPtr <= '0;
         count <= '0;
      end else begin
         if (doPush) wrPtr <= wrPtr + 1'b1;
         if (doPop) rdPtr <= rdPtr + 1'b1;
         count <= count + (AW+1)'(doPush) - (AW+1)'(doPop);
      end
   end
endmodule

// File: rtl/decomp_stream_sequencer.sv
// decomp_stream_sequencer: buffers compressed bytes and feeds (header,payload) pairs to decompress_handler.
// Optional WAIT watchdog enabled by defining DECOMP_SEQ_TIMEOUT_EN.
module decomp_stream_sequencer
   import decomp_pkg::*;
#(
   parameter int IDX_W = 32,
   parameter int CNT_W = 16,
   parameter int FIFO_DEPTH = 4,
   parameter int TIMEOUT_CYC = 1024
) (
   input  logic clk,
   input  logic RST,
   input  logic start,
   input  logic [IDX_W-1:0] base_byte,
   input  logic [CNT_W-1:0] total_pairs,
   decomp_stream_sequencer_if.master bus,
   output logic busy,
   output logic finished,
   output logic err
);
   seqState_t state, nextState;
   logic [7:0] in1, in2, fifoOut;
   logic [IDX_W-1:0] byteIdx;
   logic [2:0] bitIdx;
   logic work, push, pop, fifoFull, fifoEmpty, skip, timeout;
   logic [CNT_W-1:0] pairsLeft, totalPairs;
   logic [CNT_W:0] accepted;
   assign busy = state != IDLE;
   assign finished = state == DONE;
   // never accept more than the job's 2*total_pairs bytes
   assign bus.s_ready = busy & ~fifoFull & (accepted < {totalPairs, 1'b0});
   assign push = bus.s_valid & bus.s_ready;
   assign pop = ~fifoEmpty & (state == LOAD1 | state == LOAD2);
   assign skip = in1[RUN_LEN_MSB:0] == '0;
   assign bus.in1_o = in1;
   assign bus.in2_o = in2;
   assign bus.byte_idx_o = byteIdx;
   assign bus.bit_idx_o = bitIdx;
   assign bus.work_o = work;
   byte_fifo #(.DEPTH(FIFO_DEPTH)) fifo (
      .clk(clk),
      .RST(RST),
      .flush(timeout),
      .push(push),
      .pop(pop),
      .din(bus.s_data),
      .dout(fifoOut),
      .full(fifoFull),
      .empty(fifoEmpty)
   );
   always_ff @(posedge clk) begin
      state <= RST ? IDLE : nextState;
   end
   always_comb begin
      nextState = state;
      case (state)
         IDLE:    if (start) nextState = total_pairs == '0 ? DONE : LOAD1;
         LOAD1:   if (!fifoEmpty) nextState = LOAD2;
         LOAD2:   if (!fifoEmpty) nextState = !skip ? ISSUE : pairsLeft == CNT_W'(1) ? DONE : LOAD1;
         ISSUE:   nextState = WAIT;
         WAIT:    nextState = bus.done_i ? DRAIN : timeout ? IDLE : WAIT;
         DRAIN:   if (!bus.done_i) nextState = pairsLeft != '0 ? LOAD1 : DONE;
         DONE:    nextState = IDLE;
         default: nextState = IDLE;
      endcase
   end
   always_ff @(posedge clk) begin
      if (RST) begin
         in1 <= '0;
         in2 <= '0;
         byteIdx <= '0;
         bitIdx <= BIT_IDX_FRESH;
         work <= 1'b0;
         pairsLeft <= '0;
         totalPairs <= '0;
         accepted <= '0;
      end else begin
         if (push) accepted <= accepted + 1'b1;
         case (state)
            IDLE: if (start) begin
               byteIdx <= base_byte;
               bitIdx <= BIT_IDX_FRESH;
               pairsLeft <= total_pairs;
               totalPairs <= total_pairs;
               accepted <= '0;
            end
            LOAD1: if (pop) in1 <= fifoOut;
            LOAD2: if (pop) begin
               in2 <= fifoOut;
               if (skip) pairsLeft <= pairsLeft - 1'b1;
            end
            ISSUE: work <= 1'b1;
            // handler indices are taken verbatim; no local recompute
            WAIT: if (bus.done_i) begin
               byteIdx <= bus.new_byte_i;
               bitIdx <= bus.new_bit_i;
               work <= 1'b0;
               pairsLeft <= pairsLeft - 1'b1;
            end else if (timeout) work <= 1'b0;
            default: ;
         endcase
      end
   end
`ifdef DECOMP_SEQ_TIMEOUT_EN
   localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
   logic [TO_W-1:0] toCnt;
   assign timeout = state == WAIT & ~bus.done_i & toCnt == TO_W'(TIMEOUT_CYC - 1);
   always_ff @(posedge clk) begin
      if (RST) begin
         toCnt <= '0;
         err <= 1'b0;
      end else begin
         toCnt <= state == WAIT ? toCnt + 1'b1 : '0;
         if (state == IDLE & start) err <= 1'b0;
         else if (timeout) err <= 1'b1;
      end
   end
`else
   assign timeout = 1'b0;
   assign err = 1'b0;
`endif
endmodule
